pitch_snap: RTL and testbench
=============================

Name: pitch_snap

Overview:
- Sits directly downstream of the YIN period detector.
- Consumes each detected period (taumin, in samples) and finds the nearest entry in a programmable table of equal-tempered target periods.
- Computes the resampling ratio tau/target in fixed point, which the pitch-shift stage consumes.
- Sequential: binary search over the table, then a restoring divider; constant latency per result.

Parameters:
TAU_WIDTH, 11, width of period input and table entries (matches $clog2(TAUMAX)).
NUM_NOTES, 64, table entries; power of two.
FRAC, 12, fractional bits of ratio_out.
RATIO_WIDTH, 14, ratio_out width (integer bits = RATIO_WIDTH-FRAC).
MIN_TAU, 20, periods below this are unvoiced.

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
tau_in  input  TAU_WIDTH  detected period (YIN taumin)
tau_valid_in  input  1  one-cycle strobe, tau_in valid (YIN valid_out)
tbl_wen_in  input  1  table write enable
tbl_addr_in  input  $clog2(NUM_NOTES)  table write index
tbl_data_in  input  TAU_WIDTH  table write data
valid_out  output  1  one-cycle result strobe
voiced_out  output  1  1 = tau snapped, 0 = unvoiced
note_out  output  $clog2(NUM_NOTES)  chosen table index
target_tau_out  output  TAU_WIDTH  chosen table period
ratio_out  output  RATIO_WIDTH  floor(tau*2^FRAC/target), saturated
busy_out  output  1  high from capture until valid_out
drop_out  output  1  one-cycle pulse, input strobe discarded

Behaviour:
- Interface: one clock (clk_in); rst_in is synchronous, active-high.
- Reset: all outputs 0; FSM returns to IDLE from any state and abandons any result in flight, with no valid_out for it. Table contents are not altered by reset (LUTRAM allowed).
- Table:
  - Software guarantees strictly descending order: entry 0 is the longest period (lowest note).
  - Writes take effect the next cycle and are accepted only while busy_out=0. Writes while busy are ignored.
  - Read combinationally inside the block.
- FSM states: IDLE -> SEARCH -> PICK -> DIVIDE -> DONE -> IDLE.
- IDLE:
  - On tau_valid_in: latch tau, set busy_out, go to SEARCH.
  - Unvoiced flag = (tau < MIN_TAU); this covers tau=0.
- SEARCH:
  - Binary search, one table probe per cycle, exactly $clog2(NUM_NOTES) cycles.
  - Result j = smallest index with table[j] <= tau, or NUM_NOTES if none.
- PICK (1 cycle):
  - j=0 -> idx 0 (clamp high).
  - j=NUM_NOTES -> idx NUM_NOTES-1 (clamp low).
  - Otherwise pick j-1 or j by smaller |table - tau|; tie -> j-1 (longer period).
  - Latch target.
  - Saturation flag = tau >= (target << (RATIO_WIDTH-FRAC)).
- DIVIDE:
  - Restoring division of {tau, FRAC zeros} by target, one quotient bit per cycle, exactly RATIO_WIDTH cycles.
  - Runs even when saturating or unvoiced, to keep latency constant.
- DONE (1 cycle): register outputs, pulse valid_out, clear busy_out.
  - Voiced: ratio_out = saturated ? all-ones : quotient.
  - Unvoiced: voiced_out=0, note_out=0, target_tau_out=0, ratio_out=1<<FRAC.
- Latency:
  - valid_out rises exactly L = $clog2(NUM_NOTES)+RATIO_WIDTH+3 cycles after the edge that sampled tau_valid_in (23 at defaults).
  - Outputs hold until the next valid_out or reset.
- Back-pressure:
  - tau_valid_in while busy_out=1 (including the DONE cycle) is discarded; drop_out pulses the following cycle. The in-flight result is unaffected.
  - A strobe in the cycle after valid_out is accepted.
- Next capture is possible the cycle after DONE; minimum strobe spacing is L+1 cycles, far below YIN's window rate.

Test Plan:
- Load table[i]=1000-10*i (1000..370). tau=805 -> tie between idx19 (810) and idx20 (800); note_out=19, target=810, ratio_out=4070, voiced_out=1, valid_out exactly 23 cycles after strobe.
- Same table, tau=803 -> note_out=20, target=800, ratio_out=4111; tau=800 exact -> note_out=20, ratio_out=4096.
- Clamps: tau=1500 -> note 0, target 1000, ratio 6144. tau=100 -> note 63, target 370, ratio 1107.
- Reload table[i]=400-4*i; tau=2000 -> note 0, target 400, ratio_out=16383 (saturated). Confirm the write issued while busy is ignored (readback via subsequent snap).
- Unvoiced: tau=0 and tau=19 -> voiced_out=0, ratio_out=4096, target 0, note 0, same 23-cycle latency. tau=20 -> voiced.
- Second strobe 5 cycles after first -> drop_out pulse 1 cycle later, first result correct. rst_in pulse mid-DIVIDE -> no valid_out, outputs 0, next strobe processed normally with old table intact.

Source files
------------

// File: rtl/pitch_snap.sv
// pitch_snap: snaps a detected period to the nearest table note and computes the
// tau/target resampling ratio using a binary search followed by a restoring divider.
module pitch_snap #(
  parameter int TAU_WIDTH   = 11,
  parameter int NUM_NOTES   = 64,
  parameter int FRAC        = 12,
  parameter int RATIO_WIDTH = 14,
  parameter int MIN_TAU     = 20
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic [TAU_WIDTH-1:0]         tau_in,
  input  logic                         tau_valid_in,
  input  logic                         tbl_wen_in,
  input  logic [$clog2(NUM_NOTES)-1:0] tbl_addr_in,
  input  logic [TAU_WIDTH-1:0]         tbl_data_in,
  output logic                         valid_out,
  output logic                         voiced_out,
  output logic [$clog2(NUM_NOTES)-1:0] note_out,
  output logic [TAU_WIDTH-1:0]         target_tau_out,
  output logic [RATIO_WIDTH-1:0]       ratio_out,
  output logic                         busy_out,
  output logic                         drop_out
);
  localparam int AW = $clog2(NUM_NOTES);
  localparam int IW = RATIO_WIDTH - FRAC;
  localparam int CW = $clog2(AW + RATIO_WIDTH + 1);
  typedef enum logic [2:0] {IDLE, SEARCH, PICK, DIVIDE, DONE} state_t;
  state_t state_q, state_d;
  logic [TAU_WIDTH-1:0] tbl_q [NUM_NOTES];
  logic [TAU_WIDTH-1:0] tau_q, tgt_q, rem_q, rem_d;
  logic [AW-1:0] pos_q, note_q, probe, pick;
  logic [CW-1:0] cnt_q;
  logic [RATIO_WIDTH-1:0] dv_q;
  logic [TAU_WIDTH:0] rem_sh;
  logic unv_q, sat_q, ge;
  // pos_q ends as the count of entries longer than tau (capped at NUM_NOTES-1),
  // so the neighbour above it is always strictly longer than tau when pos_q != 0.
  always_comb begin
    busy_out = state_q != IDLE;
    probe = pos_q + (AW'(1) << cnt_q) - AW'(1);
    pick = (pos_q != '0 && tbl_q[pos_q] <= tau_q &&
            tau_q - tbl_q[pos_q] >= tbl_q[pos_q - AW'(1)] - tau_q) ? pos_q - AW'(1) : pos_q;
    rem_sh = {rem_q, dv_q[RATIO_WIDTH-1]};
    ge = rem_sh >= {1'b0, tgt_q};
    rem_d = ge ? TAU_WIDTH'(rem_sh - {1'b0, tgt_q}) : rem_sh[TAU_WIDTH-1:0];
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = tau_valid_in ? SEARCH : IDLE;
      SEARCH:  state_d = cnt_q == '0 ? PICK : SEARCH;
      PICK:    state_d = DIVIDE;
      DIVIDE:  state_d = cnt_q == '0 ? DONE : DIVIDE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_in) state_q <= rst_in ? IDLE : state_d;
  always_ff @(posedge clk_in)
    if (tbl_wen_in && !busy_out) tbl_q[tbl_addr_in] <= tbl_data_in;
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_out      <= 1'b0;
      voiced_out     <= 1'b0;
      note_out       <= '0;
      target_tau_out <= '0;
      ratio_out      <= '0;
      drop_out       <= 1'b0;
    end else begin
      valid_out <= state_q == DONE;
      drop_out  <= tau_valid_in && busy_out;
      if (state_q == DONE) begin
        voiced_out     <= !unv_q;
        note_out       <= unv_q ? '0 : note_q;
        target_tau_out <= unv_q ? '0 : tgt_q;
        ratio_out      <= unv_q ? RATIO_WIDTH'(1) << FRAC : (sat_q ? '1 : dv_q);
      end
    end
    // dv_q shifts out the low dividend bits while the quotient shifts in behind them
    case (state_q)
      IDLE: if (tau_valid_in) begin
        tau_q <= tau_in;
        unv_q <= tau_in < TAU_WIDTH'(MIN_TAU);
        pos_q <= '0;
        cnt_q <= CW'(AW - 1);
      end
      SEARCH: begin
        if (tbl_q[probe] > tau_q) pos_q <= probe + AW'(1);
        cnt_q <= cnt_q - 1'b1;
      end
      PICK: begin
        tgt_q  <= tbl_q[pick];
        note_q <= pick;
        sat_q  <= {{IW{1'b0}}, tau_q} >= {tbl_q[pick], {IW{1'b0}}};
        rem_q  <= tau_q >> IW;
        dv_q   <= {tau_q[IW-1:0], {FRAC{1'b0}}};
        cnt_q  <= CW'(RATIO_WIDTH - 1);
      end
      DIVIDE: begin
        rem_q <= rem_d;
        dv_q  <= {dv_q[RATIO_WIDTH-2:0], ge};
        cnt_q <= cnt_q - 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_pitch_snap.sv
// tb_pitch_snap: vector table, corner sequences and randomized checks against a nearest-note model.
module tb_pitch_snap;
  logic clk_in = 0, rst_in = 1, tau_valid_in = 0, tbl_wen_in = 0;
  logic [10:0] tau_in = 0, tbl_data_in = 0;
  logic [5:0] tbl_addr_in = 0;
  logic valid_out, voiced_out, busy_out, drop_out;
  logic [5:0] note_out;
  logic [10:0] target_tau_out;
  logic [13:0] ratio_out;
  int tests = 0, fails = 0, cyc = 0, s0 = 0;
  int mt [64];
  typedef struct {int tau; int v; int n; int t; int r;} vec_t;
  vec_t vecs [11];

  pitch_snap dut (
    .clk_in(clk_in), .rst_in(rst_in), .tau_in(tau_in), .tau_valid_in(tau_valid_in),
    .tbl_wen_in(tbl_wen_in), .tbl_addr_in(tbl_addr_in), .tbl_data_in(tbl_data_in),
    .valid_out(valid_out), .voiced_out(voiced_out), .note_out(note_out),
    .target_tau_out(target_tau_out), .ratio_out(ratio_out), .busy_out(busy_out),
    .drop_out(drop_out)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Nearest entry by exhaustive scan; strict '<' keeps the lower index (longer period) on ties.
  task automatic model(input int tau, output int v, output int n, output int t, output int r);
    if (tau < 20) begin
      v = 0; n = 0; t = 0; r = 4096;
    end else begin
      n = 0;
      for (int i = 1; i < 64; i++)
        if ((mt[i] > tau ? mt[i] - tau : tau - mt[i]) < (mt[n] > tau ? mt[n] - tau : tau - mt[n])) n = i;
      t = mt[n];
      v = 1;
      r = (tau >= 4 * t) ? 16383 : (tau * 4096) / t;
    end
  endtask

  task automatic load(input int base, input int step);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk_in);
      tbl_wen_in = 1; tbl_addr_in = 6'(i); tbl_data_in = 11'(base - step * i);
      mt[i] = base - step * i;
    end
    @(negedge clk_in);
    tbl_wen_in = 0;
  endtask

  task automatic start(input int t);
    @(negedge clk_in);
    tau_in = 11'(t); tau_valid_in = 1; s0 = cyc;
    @(negedge clk_in);
    tau_valid_in = 0;
    chk("busy after capture", int'(busy_out), 1);
  endtask

  task automatic wait_result(input string nm, input int v, input int n, input int t, input int r);
    while (!valid_out && cyc - s0 < 60) @(negedge clk_in);
    chk({nm, " latency"}, cyc - s0, 23);
    chk({nm, " voiced"}, int'(voiced_out), v);
    chk({nm, " note"}, int'(note_out), n);
    chk({nm, " target"}, int'(target_tau_out), t);
    chk({nm, " ratio"}, int'(ratio_out), r);
    chk({nm, " busy at valid"}, int'(busy_out), 0);
  endtask

  initial begin
    int v, n, t, r, nv, tau, prev;
    vecs[0]  = '{805, 1, 19, 810, 4070};
    vecs[1]  = '{803, 1, 20, 800, 4111};
    vecs[2]  = '{800, 1, 20, 800, 4096};
    vecs[3]  = '{1500, 1, 0, 1000, 6144};
    vecs[4]  = '{100, 1, 63, 370, 1107};
    vecs[5]  = '{0, 0, 0, 0, 4096};
    vecs[6]  = '{19, 0, 0, 0, 4096};
    vecs[7]  = '{20, 1, 63, 370, 221};
    vecs[8]  = '{995, 1, 0, 1000, 4075};
    vecs[9]  = '{375, 1, 62, 380, 4042};
    vecs[10] = '{2047, 1, 0, 1000, 8384};
    repeat (3) @(negedge clk_in);
    rst_in = 0;
    @(negedge clk_in);
    chk("reset valid", int'(valid_out), 0);
    chk("reset voiced", int'(voiced_out), 0);
    chk("reset ratio", int'(ratio_out), 0);
    chk("reset busy", int'(busy_out), 0);
    chk("reset drop", int'(drop_out), 0);
    load(1000, 10);
    foreach (vecs[i]) begin
      start(vecs[i].tau);
      wait_result($sformatf("vec tau=%0d", vecs[i].tau), vecs[i].v, vecs[i].n, vecs[i].t, vecs[i].r);
      @(negedge clk_in);
      chk("valid is a pulse", int'(valid_out), 0);
      chk("ratio holds", int'(ratio_out), vecs[i].r);
    end
    // strobe while searching is dropped; in-flight result unaffected
    start(805);
    repeat (4) @(negedge clk_in);
    tau_in = 100; tau_valid_in = 1;
    @(negedge clk_in);
    tau_valid_in = 0;
    chk("drop pulse", int'(drop_out), 1);
    @(negedge clk_in);
    chk("drop one cycle", int'(drop_out), 0);
    wait_result("after drop", 1, 19, 810, 4070);
    // strobe in DONE is dropped, strobe in the valid cycle is accepted
    start(803);
    while (cyc - s0 < 22) @(negedge clk_in);
    chk("busy in done", int'(busy_out), 1);
    tau_in = 100; tau_valid_in = 1;
    @(negedge clk_in);
    chk("valid after done", int'(valid_out), 1);
    chk("done result ratio", int'(ratio_out), 4111);
    chk("drop in done", int'(drop_out), 1);
    tau_in = 1500; tau_valid_in = 1; s0 = cyc;
    @(negedge clk_in);
    tau_valid_in = 0;
    chk("no drop in valid cycle", int'(drop_out), 0);
    wait_result("back to back", 1, 0, 1000, 6144);
    // reset mid-divide abandons the result
    start(1500);
    repeat (11) @(negedge clk_in);
    rst_in = 1;
    @(negedge clk_in);
    rst_in = 0;
    nv = 0;
    repeat (30) begin
      @(negedge clk_in);
      if (valid_out) nv++;
    end
    chk("no valid after reset", nv, 0);
    chk("reset voiced", int'(voiced_out), 0);
    chk("reset note", int'(note_out), 0);
    chk("reset target", int'(target_tau_out), 0);
    chk("reset ratio", int'(ratio_out), 0);
    chk("reset busy", int'(busy_out), 0);
    start(805);
    wait_result("post reset", 1, 19, 810, 4070);
    // second table, saturation and write-while-busy
    load(400, 4);
    start(2000);
    @(negedge clk_in);
    tbl_wen_in = 1; tbl_addr_in = 0; tbl_data_in = 500;
    @(negedge clk_in);
    tbl_wen_in = 0;
    wait_result("sat 2000", 1, 0, 400, 16383);
    start(2000);
    wait_result("busy write ignored", 1, 0, 400, 16383);
    start(1600);
    wait_result("sat edge 1600", 1, 0, 400, 16383);
    start(1599);
    wait_result("below sat 1599", 1, 0, 400, 16373);
    // randomized tables and periods against the model
    for (int k = 0; k < 3; k++) begin
      prev = $urandom_range(1500, 2047);
      for (int i = 0; i < 64; i++) begin
        @(negedge clk_in);
        tbl_wen_in = 1; tbl_addr_in = 6'(i); tbl_data_in = 11'(prev);
        mt[i] = prev;
        prev = prev - $urandom_range(1, 20);
      end
      @(negedge clk_in);
      tbl_wen_in = 0;
      for (int j = 0; j < 40; j++) begin
        tau = $urandom_range(0, 2047);
        if ($urandom_range(0, 3) == 0) tau = mt[$urandom_range(0, 63)] + $urandom_range(0, 4) - 2;
        if (tau < 0) tau = 0;
        if (tau > 2047) tau = 2047;
        model(tau, v, n, t, r);
        start(tau);
        wait_result($sformatf("rand tau=%0d", tau), v, n, t, r);
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
